csr_hpm_counters: RTL and testbench
===================================

Name: csr_hpm_counters

Overview:
- Parametrised machine-level counter bank for the core CSR file: writable mcycle and minstret, COUNTER_COUNT mhpmcounterN with mhpmeventN selectors, mcountinhibit, and user read-only shadows (cycle/instret/hpmcounterN).
- Sits beside the trap unit inside the CSR file and uses the same read-select protocol: a combinational csrReadData plus a csrRequestOutput hit flag.
- Unlike the fixed read-only timers, every counter is software-writable, can be inhibited, counts a selectable event, and has a configurable width.

Parameters:
- COUNTER_COUNT, 4, number of hpm counters; indices 3..COUNTER_COUNT+2; legal range 1..29.
- EVENT_COUNT, 8, width of the events input; selector value k (1..EVENT_COUNT) counts events[k-1].
- COUNTER_WIDTH, 64, implemented bits per counter (mcycle, minstret, hpm); legal range 33..64.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-low.
- csrWriteEnable  in  1  CSR write strobe.
- csrReadEnable  in  1  CSR read strobe.
- csrWriteAddress  in  12  write address.
- csrReadAddress  in  12  read address.
- csrWriteData  in  32  write data.
- csrReadData  out  32  read data; 0 when there is no hit.
- csrRequestOutput  out  1  read address hit while csrReadEnable is high.
- instructionCompleted  in  1  retire pulse, counted by minstret.
- events  in  EVENT_COUNT  per-cycle event pulses.
- overflowInterrupt  out  1  OR of pending overflows (feature only; tied 0 otherwise).

Behaviour:
- Address map:
  - mcycle B00/B80, minstret B02/B82, mhpmcounterN B00+N / B80+N.
  - mhpmeventN 320+N, mcountinhibit 320.
  - User shadows C00/C80, C02/C82, C00+N/C80+N are read-only.
  - C01/C81 (time) are not decoded here.
- Reads are combinational, with no latency.
  - Lower address returns counter[31:0].
  - Upper address returns counter[COUNTER_WIDTH-1:32], zero-extended to 32.
  - Unimplemented indices in B03..B1F / 323..33F read 0 and assert csrRequestOutput (WARL zero).
- Writes take effect on the clock edge.
  - Lower write replaces bits [31:0]; upper write replaces bits [COUNTER_WIDTH-1:32], excess bits discarded.
  - Writes to user shadows and unimplemented indices are ignored.
- mcountinhibit:
  - Implemented bits are 0 (CY), 2 (IR) and 3..COUNTER_COUNT+2; all others read 0.
  - An inhibited counter holds its value and remains readable and writable.
- mhpmeventN[7:0] selector:
  - 0 or a value above EVENT_COUNT counts nothing, but the value is stored as written.
  - Bits [30:8] read 0.
- Per-cycle increment:
  - mcycle increments by 1 when not inhibited.
  - minstret increments on instructionCompleted.
  - hpmN increments when events[sel-1] is high.
- Wrap: all-ones + 1 -> 0 at COUNTER_WIDTH bits.
- Simultaneous events:
  - A CSR write to a counter in the same cycle as its increment: the write wins and that increment is lost.
  - A write to the lower half leaves the upper half unchanged.
  - A selector or inhibit write takes effect from the next cycle; the old value governs the write cycle.
- Reset, including mid-count: all counters, selectors, inhibit and overflow state go to 0; csrReadData = 0; csrRequestOutput = 0; overflowInterrupt = 0.

Optional Feature:
- Macro: CSR_HPM_OVERFLOW_EN.
- Enabled:
  - mhpmeventN bit 31 (OF) is set when hpmN wraps from all-ones to 0, unless the write-wins rule applies.
  - OF is software writable; a write of 0 clears it, and set-by-wrap has priority over a simultaneous clear.
  - overflowInterrupt = OR of all OF bits, registered, asserted the cycle after the wrap.
- Disabled: bit 31 reads 0, writes to it are ignored, and overflowInterrupt is constant 0.

Test Plan:
- Reset release, read B00 over 3 idle cycles -> values increase by 1 each cycle; read F11 -> csrRequestOutput 0, data 0.
- Write B03=FFFFFFFF and B83=FFFFFFFF, set 323 = 1, pulse events[0] once -> B03 and B83 read 0 (wrap). With CSR_HPM_OVERFLOW_EN: 323 reads 80000001 and overflowInterrupt goes high next cycle; write 323 = 1 -> it clears.
- Write 320 = 00000005, hold instructionCompleted high for 4 cycles -> mcycle and minstret unchanged; write 320 = 0 -> both resume.
- mhpmevent4 = 2, events[1] high, write B04 = 00000010 in the same cycle -> reads 10 next cycle, 11 the cycle after.
- COUNTER_WIDTH = 40: write B80 = FFFFFFFF -> reads 000000FF; write C00 = 5 -> ignored, and read C00 equals B00.
- Assert rst low mid-count with counters nonzero -> all reads 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/csr_hpm_counters.sv
// csr_hpm_counters: machine-level counter bank for the CSR file.
//   mcycle (B00/B80), minstret (B02/B82), mhpmcounterN (B00+N/B80+N, N=3..COUNTER_COUNT+2),
//   mhpmeventN selectors (320+N), mcountinhibit (320), read-only user shadows (C00+x/C80+x).
//   Unimplemented indices in B03..B1F / B83..B9F / C03..C1F / C83..C9F / 323..33F read as zero with a hit.
// Optional feature (macro CSR_HPM_OVERFLOW_EN): mhpmeventN[31] overflow flag plus a
// registered overflowInterrupt; without it bit 31 reads 0 and overflowInterrupt is tied 0.
// Ports:
//   clk, rst (async, active-low)
//   csrWriteEnable/csrWriteAddress/csrWriteData : CSR write port, effective on the clock edge
//   csrReadEnable/csrReadAddress                : CSR read port, combinational
//   csrReadData/csrRequestOutput                : read data (0 on miss) and hit flag
//   instructionCompleted                        : retire pulse for minstret
//   events[EVENT_COUNT-1:0]                     : per-cycle event pulses for the hpm counters
//   overflowInterrupt                           : OR of pending overflow flags (feature only)
module csr_hpm_counters #(
   parameter int unsigned COUNTER_COUNT = 4,
   parameter int unsigned EVENT_COUNT   = 8,
   parameter int unsigned COUNTER_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   csrWriteEnable,
   input  logic                   csrReadEnable,
   input  logic [11:0]            csrWriteAddress,
   input  logic [11:0]            csrReadAddress,
   input  logic [31:0]            csrWriteData,
   output logic [31:0]            csrReadData,
   output logic                   csrRequestOutput,
   input  logic                   instructionCompleted,
   input  logic [EVENT_COUNT-1:0] events,
   output logic                   overflowInterrupt
);

   // Index space mirrors the CSR low address bits: 0 = cycle, 1 = time (absent), 2 = instret, 3.. = hpm.
   localparam int unsigned NCNT = COUNTER_COUNT + 3;
   localparam logic [63:0] INH_MASK64 = ((64'd1 << NCNT) - 64'd1) & ~64'd2;
   localparam logic [31:0] INH_MASK = INH_MASK64[31:0];

   localparam logic [6:0] PAGE_MLO = 7'h58;  // B00..B1F
   localparam logic [6:0] PAGE_MHI = 7'h5C;  // B80..B9F
   localparam logic [6:0] PAGE_ULO = 7'h60;  // C00..C1F
   localparam logic [6:0] PAGE_UHI = 7'h64;  // C80..C9F
   localparam logic [6:0] PAGE_EVT = 7'h19;  // 320..33F

   logic [COUNTER_WIDTH-1:0] cnt      [NCNT];
   logic [COUNTER_WIDTH-1:0] cnt_next [NCNT];
   logic [7:0]               sel      [NCNT];
   logic [7:0]               sel_next [NCNT];
   logic [31:0]              inh, inh_next;
   logic [NCNT-1:0]          of, of_next;

   logic [6:0] wpage, rpage;
   logic [4:0] widx, ridx;
   logic       rd_hit;
   logic [31:0] rd_val;
   logic [63:0] ext;

   assign wpage = csrWriteAddress[11:5];
   assign widx  = csrWriteAddress[4:0];
   assign rpage = csrReadAddress[11:5];
   assign ridx  = csrReadAddress[4:0];

   function automatic logic event_hit(input logic [7:0] s, input logic [EVENT_COUNT-1:0] ev);
      logic h;
      h = 1'b0;
      for (int unsigned k = 1; k <= EVENT_COUNT; k++)
         if (s == 8'(k)) h = ev[k-1];
      return h;
   endfunction

`ifdef CSR_HPM_OVERFLOW_EN
   logic [NCNT-1:0] wrap;
`endif

   always_comb begin
      inh_next = inh;
      if (csrWriteEnable && wpage == PAGE_EVT && widx == 5'd0)
         inh_next = csrWriteData & INH_MASK;
`ifdef CSR_HPM_OVERFLOW_EN
      wrap = '0;
`endif
      of_next = of;
      for (int unsigned i = 0; i < NCNT; i++) begin
         logic inc;
         logic wr_lo;
         logic wr_hi;
         logic wr_evt;
         inc = 1'b0;
         if (!inh[i]) begin
            if (i == 0)      inc = 1'b1;
            else if (i == 2) inc = instructionCompleted;
            else if (i >= 3) inc = event_hit(sel[i], events);
         end
         wr_lo  = csrWriteEnable && (i != 1) && wpage == PAGE_MLO && widx == 5'(i);
         wr_hi  = csrWriteEnable && (i != 1) && wpage == PAGE_MHI && widx == 5'(i);
         wr_evt = csrWriteEnable && (i >= 3) && wpage == PAGE_EVT && widx == 5'(i);

         // A write to either half replaces the increment for that cycle.
         cnt_next[i] = cnt[i];
         if (wr_lo)
            cnt_next[i][31:0] = csrWriteData;
         else if (wr_hi)
            cnt_next[i][COUNTER_WIDTH-1:32] = csrWriteData[COUNTER_WIDTH-33:0];
         else if (inc) begin
            cnt_next[i] = cnt[i] + COUNTER_WIDTH'(1);
`ifdef CSR_HPM_OVERFLOW_EN
            wrap[i] = (i >= 3) && (&cnt[i]);
`endif
         end

         sel_next[i] = sel[i];
         if (wr_evt) sel_next[i] = csrWriteData[7:0];

`ifdef CSR_HPM_OVERFLOW_EN
         if (wr_evt) of_next[i] = csrWriteData[31];
         if (wrap[i]) of_next[i] = 1'b1;  // wrap beats a simultaneous clear
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inh <= '0;
         of  <= '0;
         for (int unsigned i = 0; i < NCNT; i++) begin
            cnt[i] <= '0;
            sel[i] <= '0;
         end
      end else begin
         inh <= inh_next;
         of  <= of_next;
         for (int unsigned i = 0; i < NCNT; i++) begin
            cnt[i] <= cnt_next[i];
            sel[i] <= sel_next[i];
         end
      end
   end

`ifdef CSR_HPM_OVERFLOW_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) overflowInterrupt <= 1'b0;
      else      overflowInterrupt <= |of;
   end
`else
   assign overflowInterrupt = 1'b0;
`endif

   always_comb begin
      rd_hit = 1'b0;
      rd_val = '0;
      ext    = '0;
      case (rpage)
         PAGE_MLO, PAGE_ULO, PAGE_MHI, PAGE_UHI: begin
            if (ridx != 5'd1) begin
               rd_hit = 1'b1;
               for (int unsigned i = 0; i < NCNT; i++)
                  if (ridx == 5'(i)) ext = 64'(cnt[i]);
               rd_val = (rpage == PAGE_MHI || rpage == PAGE_UHI) ? ext[63:32] : ext[31:0];
            end
         end
         PAGE_EVT: begin
            if (ridx == 5'd0) begin
               rd_hit = 1'b1;
               rd_val = inh;
            end else if (ridx >= 5'd3) begin
               rd_hit = 1'b1;
               for (int unsigned i = 3; i < NCNT; i++)
                  if (ridx == 5'(i)) rd_val = {of[i], 23'd0, sel[i]};
            end
         end
         default: ;
      endcase
   end

   // Reset forces the read port quiet even though decode is purely combinational.
   assign csrRequestOutput = rst && csrReadEnable && rd_hit;
   assign csrReadData      = csrRequestOutput ? rd_val : '0;

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Self-checking bench for csr_hpm_counters (COUNTER_COUNT=4, EVENT_COUNT=8, COUNTER_WIDTH=40).
// Directed scenarios followed by a randomized phase, all checked against a behavioural model.
module tb_csr_hpm_counters;
   localparam int unsigned CC = 4;
   localparam int unsigned EC = 8;
   localparam int unsigned CW = 40;
   localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          csrWriteEnable = 1'b0;
   logic          csrReadEnable = 1'b0;
   logic [11:0]   csrWriteAddress = '0;
   logic [11:0]   csrReadAddress = '0;
   logic [31:0]   csrWriteData = '0;
   logic [31:0]   csrReadData;
   logic          csrRequestOutput;
   logic          instructionCompleted = 1'b0;
   logic [EC-1:0] events = '0;
   logic          overflowInterrupt;

   always #5 clk = ~clk;

   csr_hpm_counters #(.COUNTER_COUNT(CC), .EVENT_COUNT(EC), .COUNTER_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .csrWriteEnable(csrWriteEnable), .csrReadEnable(csrReadEnable),
      .csrWriteAddress(csrWriteAddress), .csrReadAddress(csrReadAddress),
      .csrWriteData(csrWriteData), .csrReadData(csrReadData),
      .csrRequestOutput(csrRequestOutput), .instructionCompleted(instructionCompleted),
      .events(events), .overflowInterrupt(overflowInterrupt)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] m_cnt [32];
   logic [7:0]  m_sel [32];
   bit          m_of  [32];
   logic [31:0] m_inh;
   bit          m_irq;

   function automatic bit impl(input int i);
      return i == 0 || i == 2 || (i >= 3 && i < int'(CC) + 3);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_cnt[i] = '0; m_sel[i] = '0; m_of[i] = 0;
      end
      m_inh = '0;
      m_irq = 0;
   endtask

   task automatic model_step();
      logic [63:0] nc [32];
      logic [7:0]  ns [32];
      bit          no [32];
      logic [31:0] ni;
      bit          nirq;
      int          a;
      bit          ev;
      int          s;
      a = int'(csrWriteAddress);
      ni = m_inh;
      nirq = 0;
`ifdef CSR_HPM_OVERFLOW_EN
      for (int i = 0; i < 32; i++) nirq |= m_of[i];
`endif
      for (int i = 0; i < 32; i++) begin
         nc[i] = m_cnt[i]; ns[i] = m_sel[i]; no[i] = m_of[i];
         if (!impl(i)) continue;
         ev = 0;
         if (i == 0) ev = 1;
         else if (i == 2) ev = instructionCompleted;
         else begin
            s = int'(m_sel[i]);
            if (s >= 1 && s <= int'(EC)) ev = events[s-1];
         end
         if (m_inh[i]) ev = 0;
         if (csrWriteEnable && a == 'hB00 + i)
            nc[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | 64'(csrWriteData);
         else if (csrWriteEnable && a == 'hB80 + i)
            nc[i] = ((64'(csrWriteData) << 32) | (m_cnt[i] & 64'hFFFF_FFFF)) & MASK;
         else if (ev) begin
            if (m_cnt[i] == MASK) begin
               nc[i] = 0;
`ifdef CSR_HPM_OVERFLOW_EN
               if (i >= 3) no[i] = 1;
`endif
            end else nc[i] = m_cnt[i] + 1;
         end
         if (i >= 3 && csrWriteEnable && a == 'h320 + i) begin
            ns[i] = csrWriteData[7:0];
`ifdef CSR_HPM_OVERFLOW_EN
            if (!(ev && m_cnt[i] == MASK)) no[i] = csrWriteData[31];
`endif
         end
      end
      if (csrWriteEnable && a == 'h320) begin
         ni = '0;
         for (int i = 0; i < 32; i++) if (impl(i)) ni[i] = csrWriteData[i];
      end
      for (int i = 0; i < 32; i++) begin
         m_cnt[i] = nc[i]; m_sel[i] = ns[i]; m_of[i] = no[i];
      end
      m_inh = ni;
      m_irq = nirq;
   endtask

   task automatic model_read(input int a, output bit hit, output logic [31:0] d);
      int i;
      logic [63:0] v;
      hit = 0; d = '0;
      i = a % 32;
      if (((a >= 'hB00 && a <= 'hB1F) || (a >= 'hC00 && a <= 'hC1F)) && i != 1) begin
         hit = 1;
         if (impl(i)) begin v = m_cnt[i]; d = v[31:0]; end
      end else if (((a >= 'hB80 && a <= 'hB9F) || (a >= 'hC80 && a <= 'hC9F)) && i != 1) begin
         hit = 1;
         if (impl(i)) begin v = m_cnt[i] >> 32; d = v[31:0]; end
      end else if (a == 'h320) begin
         hit = 1; d = m_inh;
      end else if (a >= 'h323 && a <= 'h33F) begin
         hit = 1;
         if (impl(i)) d = {m_of[i], 23'd0, m_sel[i]};
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      if (rst) model_step();
      #1;
      check("irq", {63'd0, overflowInterrupt}, {63'd0, m_irq});
   endtask

   task automatic rd(input string tag, input logic [11:0] a, output logic [31:0] got);
      bit eh;
      logic [31:0] ed;
      csrReadAddress = a;
      csrReadEnable = 1'b1;
      #1;
      model_read(int'(a), eh, ed);
      if (!rst) begin eh = 0; ed = '0; end
      check({tag, "_data"}, 64'(csrReadData), 64'(ed));
      check({tag, "_hit"}, {63'd0, csrRequestOutput}, {63'd0, eh});
      got = csrReadData;
      csrReadEnable = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csrWriteEnable = 1'b1; csrWriteAddress = a; csrWriteData = d;
      tick();
      csrWriteEnable = 1'b0;
   endtask

   logic [11:0] wlist [20] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                               12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'hB07, 12'h320, 12'h323, 12'h324,
                               12'h325, 12'h326, 12'hC00, 12'hC03};
   logic [11:0] rlist [24] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB07, 12'hB01,
                               12'hB80, 12'hB82, 12'hB83, 12'hB86, 12'hB9F, 12'hB81, 12'hC00, 12'hC04,
                               12'hC83, 12'hC01, 12'h320, 12'h321, 12'h322, 12'h324, 12'h33F, 12'hF11};

   initial begin
      logic [31:0] r, r2;
      logic [11:0] a;
      logic [31:0] d;
      model_reset();

      // reset state, read port quiet while held in reset
      repeat (2) @(posedge clk);
      #1;
      rd("rst_b00", 12'hB00, r);
      check("rst_irq", {63'd0, overflowInterrupt}, 64'd0);
      rst = 1'b1;

      // free-running mcycle
      for (int k = 0; k < 3; k++) begin
         tick();
         rd("idle_b00", 12'hB00, r);
         check("idle_b00_lit", 64'(r), 64'(k + 1));
      end
      rd("f11", 12'hF11, r);
      check("f11_lit", 64'(r), 64'd0);

      // hpm3 wrap at full width
      wr(12'hB03, 32'hFFFF_FFFF);
      wr(12'hB83, 32'hFFFF_FFFF);
      wr(12'h323, 32'h0000_0001);
      events = 8'h01;
      tick();
      events = '0;
      rd("wrap_lo", 12'hB03, r);
      check("wrap_lo_lit", 64'(r), 64'd0);
      rd("wrap_hi", 12'hB83, r);
      rd("wrap_sel", 12'h323, r);
      tick();
      tick();
      wr(12'h323, 32'h0000_0001);
      rd("of_clear", 12'h323, r);
      check("of_clear_lit", 64'(r), 64'h1);

      // inhibit cycle and instret
      wr(12'h320, 32'h0000_0005);
      instructionCompleted = 1'b1;
      rd("inh_cy0", 12'hB00, r);
      rd("inh_ir0", 12'hB02, r2);
      repeat (4) tick();
      rd("inh_cy1", 12'hB00, d);
      check("inh_cy_hold", 64'(d), 64'(r));
      rd("inh_ir1", 12'hB02, d);
      check("inh_ir_hold", 64'(d), 64'(r2));
      wr(12'h320, 32'h0);
      tick();
      rd("resume_cy", 12'hB00, r);
      rd("resume_ir", 12'hB02, r);
      instructionCompleted = 1'b0;

      // write wins over same-cycle increment
      wr(12'h324, 32'h2);
      events = 8'h02;
      wr(12'hB04, 32'h10);
      rd("ww0", 12'hB04, r);
      check("ww0_lit", 64'(r), 64'h10);
      tick();
      rd("ww1", 12'hB04, r);
      check("ww1_lit", 64'(r), 64'h11);
      events = '0;

      // implemented width and read-only shadow
      wr(12'hB80, 32'hFFFF_FFFF);
      rd("w40", 12'hB80, r);
      check("w40_lit", 64'(r), 64'hFF);
      wr(12'hC00, 32'h5);
      rd("ro_c00", 12'hC00, r);
      rd("ro_b00", 12'hB00, r2);
      check("ro_equal", 64'(r), 64'(r2));

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         events = EC'($urandom);
         instructionCompleted = 1'($urandom_range(0, 1));
         csrWriteEnable = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            a = wlist[$urandom_range(0, 19)];
            case ($urandom_range(0, 3))
               0: d = 32'hFFFF_FFFF - $urandom_range(0, 3);
               1: d = $urandom_range(0, 20);
               default: d = $urandom;
            endcase
            if (a >= 12'h323 && a <= 12'h326) d = ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 10);
            if (a == 12'h320) d = $urandom & $urandom & $urandom;
            csrWriteEnable = 1'b1; csrWriteAddress = a; csrWriteData = d;
         end
         if ($urandom_range(0, 7) == 0) a = 12'($urandom);
         else a = rlist[$urandom_range(0, 23)];
         rd("rand", a, r);
         tick();
      end
      csrWriteEnable = 1'b0;
      events = '0;

      // asynchronous reset mid-count
      rst = 1'b0;
      model_reset();
      rd("arst_b00", 12'hB00, r);
      rd("arst_b03", 12'hB03, r);
      rd("arst_320", 12'h320, r);
      check("arst_irq", {63'd0, overflowInterrupt}, 64'd0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rd("post_b00", 12'hB00, r);
         rd("post_b04", 12'hB04, r);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
